// File: rtl/color_sensor_emulator_if.sv
// Control and output signals between the colour-measurement logic and the
// light-to-frequency sensor emulator.
interface color_sensor_emulator_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic [1:0]       filter;
  logic             cfg_wr;
  logic [1:0]       cfg_sel;
  logic [CNT_W-1:0] cfg_half_period;
  logic             freq;
  logic             run;
  logic [15:0]      rise_cnt;

  modport master (
    output en, filter, cfg_wr, cfg_sel, cfg_half_period,
    input  freq, run, rise_cnt
  );

  modport slave (
    input  en, filter, cfg_wr, cfg_sel, cfg_half_period,
    output freq, run, rise_cnt
  );
endinterface

// File: rtl/color_sensor_emulator.sv
// Emulated light-to-frequency sensor: drives a square wave whose half-period
// is a runtime-programmable value selected by the filter input.
module color_sensor_emulator #(
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int HP_RED        = 50,
  parameter int HP_BLUE       = 40,
  parameter int HP_CLEAR      = 20,
  parameter int HP_GREEN      = 30
) (
  input  logic                     clk,
  input  logic                     reset,
  color_sensor_emulator_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

  localparam logic [CNT_W-1:0] HP_INIT [4] = '{
    CNT_W'(HP_RED), CNT_W'(HP_BLUE), CNT_W'(HP_CLEAR), CNT_W'(HP_GREEN)
  };
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_reg;
  logic             freq_reg;
  logic             run_reg;
  logic [15:0]      rise_cnt_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       filter_q_reg;
  logic [CNT_W-1:0] hp_reg [4];
  logic [CNT_W-1:0] hp_last;

  // Zero writes are dropped so every half-period stays at least one cycle.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_hp
      always_ff @(posedge clk) begin
        if (reset) begin
          hp_reg[gi] <= HP_INIT[gi];
        end else if (bus.cfg_wr && (bus.cfg_sel == 2'(gi)) &&
                     (bus.cfg_half_period != '0)) begin
          hp_reg[gi] <= bus.cfg_half_period;
        end
      end
    end
  endgenerate

  // Compared live so a rewrite of the active channel takes effect mid-period.
  assign hp_last = hp_reg[filter_q_reg] - CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      freq_reg     <= 1'b0;
      run_reg      <= 1'b0;
      rise_cnt_reg <= '0;
      cnt_reg      <= '0;
      filter_q_reg <= 2'b00;
    end else if (!bus.en) begin
      state_reg <= IDLE;
      freq_reg  <= 1'b0;
      run_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg    <= SETTLE;
          freq_reg     <= 1'b0;
          run_reg      <= 1'b0;
          filter_q_reg <= bus.filter;
          cnt_reg      <= '0;
          rise_cnt_reg <= '0;
        end
        SETTLE: begin
          freq_reg <= 1'b0;
          if (bus.filter != filter_q_reg) begin
            filter_q_reg <= bus.filter;
            cnt_reg      <= '0;
            rise_cnt_reg <= '0;
          end else if (cnt_reg == SETTLE_LAST) begin
            state_reg <= RUN;
            run_reg   <= 1'b1;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        RUN: begin
          if (bus.filter != filter_q_reg) begin
            state_reg    <= SETTLE;
            freq_reg     <= 1'b0;
            run_reg      <= 1'b0;
            filter_q_reg <= bus.filter;
            cnt_reg      <= '0;
            rise_cnt_reg <= '0;
          end else if (cnt_reg >= hp_last) begin
            freq_reg <= ~freq_reg;
            cnt_reg  <= '0;
            if (!freq_reg && (rise_cnt_reg != 16'hFFFF)) begin
              rise_cnt_reg <= rise_cnt_reg + 16'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          freq_reg  <= 1'b0;
          run_reg   <= 1'b0;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign bus.freq     = freq_reg;
  assign bus.run      = run_reg;
  assign bus.rise_cnt = rise_cnt_reg;

endmodule

// File: tb/tb_color_sensor_emulator.sv
// Directed bench for color_sensor_emulator: settle timing, periods per channel,
// live half-period rewrites, enable drop and reset restore.
module tb_color_sensor_emulator;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   n;
  int   per;

  color_sensor_emulator_if #(.CNT_W(16)) bus ();

  color_sensor_emulator #(
    .CNT_W(16), .SETTLE_CYCLES(8),
    .HP_RED(50), .HP_BLUE(40), .HP_CLEAR(20), .HP_GREEN(30)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Steps until run (sig=0) or freq (sig=1) equals val; n=-1 if the bound expires.
  task automatic wait_for(input int sig, input logic val, output int cycles);
    logic cur;
    cycles = 0;
    do begin
      step();
      cycles++;
      cur = (sig == 0) ? bus.run : bus.freq;
    end while (cur !== val && cycles < 2000);
    if (cur !== val) cycles = -1;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [15:0] val);
    bus.cfg_wr          = 1'b1;
    bus.cfg_sel         = sel;
    bus.cfg_half_period = val;
    step();
    bus.cfg_wr          = 1'b0;
  endtask

  initial begin
    checks              = 0;
    errors              = 0;
    reset               = 1'b1;
    bus.en              = 1'b0;
    bus.filter          = 2'b00;
    bus.cfg_wr          = 1'b0;
    bus.cfg_sel         = 2'b00;
    bus.cfg_half_period = '0;
    step();
    step();
    reset = 1'b0;
    step();
    check("rst_freq", int'(bus.freq), 0);
    check("rst_run", int'(bus.run), 0);
    check("rst_rise", int'(bus.rise_cnt), 0);

    // 1: clear channel, hp=20
    bus.en     = 1'b1;
    bus.filter = 2'b10;
    wait_for(0, 1'b1, n);
    check("t1_run_lat", n, 9);
    wait_for(1, 1'b1, n);
    check("t1_first_rise", n, 20);
    check("t1_rise1", int'(bus.rise_cnt), 1);
    wait_for(1, 1'b0, n);
    check("t1_high", n, 20);
    wait_for(1, 1'b1, per);
    check("t1_period", n + per, 40);
    wait_for(1, 1'b0, n);
    wait_for(1, 1'b1, n);
    check("t1_rise3", int'(bus.rise_cnt), 3);

    // 2: switch to green while running
    bus.filter = 2'b11;
    step();
    check("t2_freq", int'(bus.freq), 0);
    check("t2_run", int'(bus.run), 0);
    check("t2_rise", int'(bus.rise_cnt), 0);
    wait_for(0, 1'b1, n);
    check("t2_run_lat", n, 8);
    wait_for(1, 1'b1, n);
    check("t2_first_rise", n, 30);
    wait_for(1, 1'b0, n);
    wait_for(1, 1'b1, per);
    check("t2_period", n + per, 60);

    // 3: red, shrink hp to 10 when cnt=30
    bus.filter = 2'b00;
    step();
    wait_for(0, 1'b1, n);
    check("t3_run_lat", n, 8);
    for (int i = 0; i < 30; i++) step();
    cfg_write(2'b00, 16'd10);
    check("t3_pre_toggle", int'(bus.freq), 0);
    step();
    check("t3_toggle", int'(bus.freq), 1);
    check("t3_rise", int'(bus.rise_cnt), 1);
    wait_for(1, 1'b0, n);
    wait_for(1, 1'b1, per);
    check("t3_period", n + per, 20);

    // 4: zero write to blue is ignored
    cfg_write(2'b01, 16'd0);
    bus.filter = 2'b01;
    step();
    wait_for(0, 1'b1, n);
    wait_for(1, 1'b1, n);
    check("t4_first_rise", n, 40);
    wait_for(1, 1'b0, n);
    wait_for(1, 1'b1, per);
    check("t4_period", n + per, 80);

    // 5: drop enable for one cycle mid half-period
    for (int i = 0; i < 10; i++) step();
    bus.en = 1'b0;
    step();
    check("t5_freq", int'(bus.freq), 0);
    check("t5_run", int'(bus.run), 0);
    check("t5_rise_hold", int'(bus.rise_cnt), 2);
    bus.en = 1'b1;
    step();
    check("t5_rise_clr", int'(bus.rise_cnt), 0);
    wait_for(0, 1'b1, n);
    check("t5_run_lat", n, 8);
    wait_for(1, 1'b1, n);
    check("t5_first_rise", n, 40);

    // 6: hp[3]=5, then reset mid-run restores 30
    cfg_write(2'b11, 16'd5);
    bus.filter = 2'b11;
    step();
    wait_for(0, 1'b1, n);
    wait_for(1, 1'b1, n);
    check("t6_hp5_rise", n, 5);
    step();
    reset = 1'b1;
    step();
    check("t6_freq", int'(bus.freq), 0);
    check("t6_run", int'(bus.run), 0);
    check("t6_rise", int'(bus.rise_cnt), 0);
    reset = 1'b0;
    wait_for(0, 1'b1, n);
    check("t6_run_lat", n, 9);
    wait_for(1, 1'b1, n);
    check("t6_first_rise", n, 30);
    wait_for(1, 1'b0, n);
    wait_for(1, 1'b1, per);
    check("t6_period", n + per, 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
